// File: rtl/block_motion.sv
// Frame-synchronous sprite position controller: advances a rectangle by a
// clamped signed velocity once per frame in blanking and bounces off screen edges.
module block_motion #(
    parameter int SCREEN_W  = 1280,
    parameter int SCREEN_H  = 720,
    parameter int WIDTH     = 128,
    parameter int HEIGHT    = 128,
    parameter int X_INIT    = 576,
    parameter int Y_INIT    = 296,
    parameter int V_TRIG    = 720,
    parameter int MAX_SPEED = 15
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic signed [5:0]  dx_in,
    input  logic signed [5:0]  dy_in,
    input  logic               pause_in,
    output logic [10:0]        x_out,
    output logic [9:0]         y_out,
    output logic [10:0]        width_out,
    output logic [9:0]         height_out,
    output logic               hit_x_out,
    output logic               hit_y_out,
    output logic               done_out
);

    localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - WIDTH);
    localparam logic signed [12:0] Y_MAX = 13'(SCREEN_H - HEIGHT);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        MOVE_X = 2'd1,
        MOVE_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    function automatic logic signed [5:0] clamp_vel(input logic signed [5:0] v);
        logic signed [6:0] vext;
        logic signed [6:0] lim;
        vext = v;
        lim  = 7'(MAX_SPEED);
        if (vext > lim) begin
            clamp_vel = 6'(lim);
        end else if (vext < -lim) begin
            clamp_vel = 6'(-lim);
        end else begin
            clamp_vel = v;
        end
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               prev_match_r;
    logic               match_s;
    logic               trig_s;
    logic               accept_s;
    logic signed [5:0]  dx_r;
    logic signed [5:0]  dy_r;
    logic [10:0]        x_sh_r;
    logic [9:0]         y_sh_r;
    logic               hx_r;
    logic               hy_r;
    logic signed [12:0] nx_s;
    logic signed [12:0] ny_s;
    logic               bounce_x_s;
    logic               bounce_y_s;
    logic [10:0]        x_next_s;
    logic [9:0]         y_next_s;

    assign width_out  = 11'(WIDTH);
    assign height_out = 10'(HEIGHT);

    assign match_s  = (hcount_in == 11'd0) && (vcount_in == 10'(V_TRIG));
    assign trig_s   = match_s && !prev_match_r;
    assign accept_s = cmd_valid_in && cmd_ready_out;

    // Edge arithmetic: candidate positions and bounce decisions
    always_comb begin
        nx_s       = $signed({2'b00, x_sh_r}) + $signed({{7{dx_r[5]}}, dx_r});
        ny_s       = $signed({3'b000, y_sh_r}) + $signed({{7{dy_r[5]}}, dy_r});
        bounce_x_s = (nx_s < 13'sd0) || (nx_s > X_MAX);
        bounce_y_s = (ny_s < 13'sd0) || (ny_s > Y_MAX);
        if (nx_s < 13'sd0) begin
            x_next_s = 11'd0;
        end else if (nx_s > X_MAX) begin
            x_next_s = 11'(X_MAX);
        end else begin
            x_next_s = nx_s[10:0];
        end
        if (ny_s < 13'sd0) begin
            y_next_s = 10'd0;
        end else if (ny_s > Y_MAX) begin
            y_next_s = 10'(Y_MAX);
        end else begin
            y_next_s = ny_s[9:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAIT: begin
                if (trig_s && !pause_in) begin
                    state_s = MOVE_X;
                end else begin
                    state_s = WAIT;
                end
            end
            MOVE_X:  state_s = MOVE_Y;
            MOVE_Y:  state_s = COMMIT;
            COMMIT:  state_s = WAIT;
            default: state_s = WAIT;
        endcase
    end

    // State register, trigger edge detect and ready flag
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r       <= WAIT;
            prev_match_r  <= 1'b0;
            cmd_ready_out <= 1'b1;
        end else begin
            state_r       <= state_s;
            prev_match_r  <= match_s;
            cmd_ready_out <= (state_s == WAIT);
        end
    end

    // Velocity, shadow position and hit flags
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dx_r   <= 6'sd0;
            dy_r   <= 6'sd0;
            x_sh_r <= 11'(X_INIT);
            y_sh_r <= 10'(Y_INIT);
            hx_r   <= 1'b0;
            hy_r   <= 1'b0;
        end else begin
            case (state_r)
                WAIT: begin
                    if (accept_s) begin
                        dx_r <= clamp_vel(dx_in);
                        dy_r <= clamp_vel(dy_in);
                    end
                end
                MOVE_X: begin
                    x_sh_r <= x_next_s;
                    hx_r   <= bounce_x_s;
                    if (bounce_x_s) begin
                        dx_r <= -dx_r;
                    end
                end
                MOVE_Y: begin
                    y_sh_r <= y_next_s;
                    hy_r   <= bounce_y_s;
                    if (bounce_y_s) begin
                        dy_r <= -dy_r;
                    end
                end
                default: begin
                    hx_r <= hx_r;
                end
            endcase
        end
    end

    // Atomic publication of the new position with one-cycle pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_out     <= 11'(X_INIT);
            y_out     <= 10'(Y_INIT);
            hit_x_out <= 1'b0;
            hit_y_out <= 1'b0;
            done_out  <= 1'b0;
        end else if (state_r == COMMIT) begin
            x_out     <= x_sh_r;
            y_out     <= y_sh_r;
            hit_x_out <= hx_r;
            hit_y_out <= hy_r;
            done_out  <= 1'b1;
        end else begin
            hit_x_out <= 1'b0;
            hit_y_out <= 1'b0;
            done_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_block_motion.sv
// Directed, table-driven bench for block_motion: one table row per frame
// command, plus hand sequences for handshake, held trigger and mid-update reset.
module tb_block_motion;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              cmd_valid;
    logic              cmd_ready;
    logic signed [5:0] dx;
    logic signed [5:0] dy;
    logic              pause;
    logic [10:0]       x;
    logic [9:0]        y;
    logic [10:0]       width;
    logic [9:0]        height;
    logic              hit_x;
    logic              hit_y;
    logic              done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    block_motion dut (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .dx_in(dx), .dy_in(dy),
        .pause_in(pause), .x_out(x), .y_out(y), .width_out(width), .height_out(height),
        .hit_x_out(hit_x), .hit_y_out(hit_y), .done_out(done)
    );

    typedef struct {
        logic              ld;
        logic signed [5:0] vx;
        logic signed [5:0] vy;
        logic              pz;
        int                reps;
        int                ex;
        int                ey;
        logic              ehx;
        logic              ehy;
        logic              edone;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One frame: trigger (optionally with a coincident command), then watch 6 cycles.
    task automatic frame(input logic ld, input logic signed [5:0] vx, input logic signed [5:0] vy,
                         input logic pz, output int dcnt, output int dat,
                         output logic hx, output logic hy);
        dcnt = 0; dat = -1; hx = 1'b0; hy = 1'b0;
        @(negedge clk);
        hcount = 11'd0; vcount = 10'd720; pause = pz; cmd_valid = ld; dx = vx; dy = vy;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                vcount = 10'd0; cmd_valid = 1'b0; pause = 1'b0;
            end
            if (done) begin
                dcnt++;
                dat = i;
            end
            hx = hx | hit_x;
            hy = hy | hit_y;
        end
    endtask

    initial begin
        int   dcnt, dat, w;
        logic hx, hy;

        tbl[0]  = '{1'b1,  6'sd0,   6'sd0,  1'b0,  1,  576, 296, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, -6'sd31,  6'sd20, 1'b0,  1,  561, 311, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1,  6'sd3,  -6'sd2,  1'b0,  1,  564, 309, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1,  6'sd15,  6'sd0,  1'b0, 39, 1149, 309, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1,  6'sd1,   6'sd0,  1'b0,  1, 1150, 309, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1,  6'sd5,   6'sd0,  1'b0,  1, 1152, 309, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0,  6'sd0,   6'sd0,  1'b0,  1, 1147, 309, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1,  6'sd0,  -6'sd15, 1'b0, 20, 1147,   9, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1,  6'sd0,  -6'sd8,  1'b0,  1, 1147,   1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1,  6'sd0,  -6'sd4,  1'b0,  1, 1147,   0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0,  6'sd0,   6'sd0,  1'b0,  1, 1147,   4, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1,  6'sd2,   6'sd2,  1'b1,  1, 1147,   4, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0,  6'sd0,   6'sd0,  1'b0,  1, 1149,   6, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1,  6'sd15,  6'sd15, 1'b0,  1, 1152,  21, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; hcount = 11'd5; vcount = 10'd0; cmd_valid = 1'b0;
        dx = 6'sd0; dy = 6'sd0; pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", int'(x), 576);
        chk("rst_y", int'(y), 296);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_pulses", int'({hit_x, hit_y, done}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("width", int'(width), 128);
        chk("height", int'(height), 128);
        chk("post_rst_ready", int'(cmd_ready), 1);

        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                frame((k == 0) ? tbl[r].ld : 1'b0, tbl[r].vx, tbl[r].vy,
                      (k == 0) ? tbl[r].pz : 1'b0, dcnt, dat, hx, hy);
            end
            chk($sformatf("row%0d_x", r), int'(x), tbl[r].ex);
            chk($sformatf("row%0d_y", r), int'(y), tbl[r].ey);
            chk($sformatf("row%0d_done_cnt", r), dcnt, int'(tbl[r].edone));
            if (tbl[r].edone) chk($sformatf("row%0d_done_at", r), dat, 3);
            chk($sformatf("row%0d_hit_x", r), int'(hx), int'(tbl[r].ehx));
            chk($sformatf("row%0d_hit_y", r), int'(hy), int'(tbl[r].ehy));
        end

        // Velocity (-15,15) after the last bounce
        frame(1'b0, 6'sd0, 6'sd0, 1'b0, dcnt, dat, hx, hy);
        chk("b1_x", int'(x), 1137);
        chk("b1_y", int'(y), 36);

        // Command raised during MOVE_X must wait for WAIT
        @(negedge clk);
        hcount = 11'd0; vcount = 10'd720;
        @(negedge clk);
        vcount = 10'd0; cmd_valid = 1'b1; dx = -6'sd2; dy = 6'sd1;
        chk("hs_ready_move_x", int'(cmd_ready), 0);
        w = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("hs_wait_bounded", int'(w < 10), 1);
        chk("hs_wait_cycles", w, 3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2_x", int'(x), 1122);
        chk("b2_y", int'(y), 51);
        frame(1'b0, 6'sd0, 6'sd0, 1'b0, dcnt, dat, hx, hy);
        chk("b3_x", int'(x), 1120);
        chk("b3_y", int'(y), 52);

        // Trigger inputs held for many cycles give exactly one update
        dcnt = 0;
        @(negedge clk);
        hcount = 11'd0; vcount = 10'd720;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        vcount = 10'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("held_done_cnt", dcnt, 1);
        chk("held_x", int'(x), 1118);
        chk("held_y", int'(y), 53);

        // Reset during MOVE_Y discards the update
        @(negedge clk);
        hcount = 11'd0; vcount = 10'd720;
        @(negedge clk);
        vcount = 10'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_x", int'(x), 576);
        chk("midrst_y", int'(y), 296);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        frame(1'b0, 6'sd0, 6'sd0, 1'b0, dcnt, dat, hx, hy);
        chk("zero_vel_done_cnt", dcnt, 1);
        chk("zero_vel_done_at", dat, 3);
        chk("zero_vel_x", int'(x), 576);
        chk("zero_vel_y", int'(y), 296);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_motion.md
# block_motion

Frame-synchronous position controller for a single rectangular sprite. It sits directly upstream of the rectangle renderer and drives that renderer's x, y, width and height inputs. Once per frame, in vertical blanking, it advances the position by a programmable signed velocity, bounces off the screen edges and publishes the new position atomically, so the renderer never sees a position change mid-frame. Velocity is loaded through a valid/ready handshake from game logic.

## Interface

Parameters:
- SCREEN_W, 1280: active width in pixels.
- SCREEN_H, 720: active height in lines.
- WIDTH, 128: sprite width, driven constant on width_out.
- HEIGHT, 128: sprite height, driven constant on height_out.
- X_INIT, 576: reset x. Must satisfy X_INIT ≤ SCREEN_W−WIDTH.
- Y_INIT, 296: reset y. Must satisfy Y_INIT ≤ SCREEN_H−HEIGHT.
- V_TRIG, 720: vcount value that starts an update. Must be in blanking.
- MAX_SPEED, 15: velocity magnitude clamp. Range 1..31.

Ports:
- clk_in, input, 1: pixel clock.
- rst_n_in, input, 1: reset, asynchronous, active-low.
- hcount_in, input, 11: current pixel column.
- vcount_in, input, 10: current line.
- cmd_valid_in, input, 1: velocity command valid.
- cmd_ready_out, output, 1: block can accept a command.
- dx_in, input, 6: signed x velocity in pixels per frame.
- dy_in, input, 6: signed y velocity in pixels per frame.
- pause_in, input, 1: when high, frame updates are skipped.
- x_out, output, 11: published sprite x.
- y_out, output, 10: published sprite y.
- width_out, output, 11: constant WIDTH.
- height_out, output, 10: constant HEIGHT.
- hit_x_out, output, 1: one-cycle pulse on a left/right edge bounce.
- hit_y_out, output, 1: one-cycle pulse on a top/bottom edge bounce.
- done_out, output, 1: one-cycle pulse when a new position is published.

## Operation

- States: WAIT, MOVE_X, MOVE_Y, COMMIT. Reset state is WAIT.
- Trigger condition: hcount_in==0 && vcount_in==V_TRIG.
  - Fires only on the first cycle the condition holds. A registered previous-match flag suppresses retrigger while the inputs stay held.
- WAIT:
  - cmd_ready_out=1.
  - On trigger with pause_in=0, go to MOVE_X.
  - On trigger with pause_in=1, stay in WAIT. The frame is skipped and no pulses are produced.
- Command accept:
  - A command is accepted when cmd_valid_in && cmd_ready_out.
  - Each component is clamped to [−MAX_SPEED, +MAX_SPEED] before it is stored in the internal dx/dy registers.
  - A command accepted in the same cycle as a trigger takes effect in that update.
- cmd_ready_out=0 in MOVE_X, MOVE_Y and COMMIT. Commands held valid wait for WAIT.
- MOVE_X:
  - Compute nx = x_shadow + dx in 13-bit signed arithmetic.
  - nx<0: x_shadow=0, dx=−dx, set hit_x.
  - nx>SCREEN_W−WIDTH: x_shadow=SCREEN_W−WIDTH, dx=−dx, set hit_x.
  - Otherwise x_shadow=nx.
- MOVE_Y: same rules as MOVE_X, using dy, SCREEN_H−HEIGHT and hit_y.
- COMMIT:
  - x_out←x_shadow, y_out←y_shadow.
  - done_out, hit_x_out and hit_y_out pulse together for one cycle.
  - Return to WAIT.
- Shadow registers are internal only. x_out and y_out change only in COMMIT.
- Velocity of 0 still runs a full update cycle and pulses done_out.

## Timing

- Reset values (asynchronous on rst_n_in=0):
  - x_out=X_INIT, y_out=Y_INIT.
  - dx=dy=0, shadows equal to the outputs.
  - hit_x_out=hit_y_out=done_out=0.
  - cmd_ready_out=1, state WAIT, previous-match flag 0.
- Trigger in cycle T: MOVE_X in T+1, MOVE_Y in T+2, COMMIT in T+3.
- New x_out/y_out and the done/hit pulses are visible in T+4 only. Pulses deassert in T+5.
- Update latency is 4 cycles. Because V_TRIG is in blanking, publication always lands in blanking.
- width_out and height_out are constant from reset.
- Reset asserted mid-update: the pending update is discarded and all outputs return to reset values immediately. After release the block waits for the next trigger.
- pause_in is sampled only at trigger. Changes during MOVE_X through COMMIT have no effect on the update in progress.

## Test plan

- Reset: hold rst_n_in=0, then release. Check x_out=576, y_out=296, cmd_ready_out=1, and all pulses 0. A trigger then gives done_out at T+4 with the position unchanged (velocity 0).
- Move: accept dx=3, dy=−2 with position (100,100), then trigger. Check x_out=103, y_out=98 and done_out=1 exactly at T+4, with no hit pulses.
- Bounce right: x=1150, dx=5. Check x_out=1152, hit_x_out=1 at T+4. The next frame gives x_out=1147. Top: y=1, dy=−4 gives y_out=0, hit_y_out=1, and y_out=4 on the next frame.
- Clamp and handshake: dx_in=−31, dy_in=20 accepted, then check dx=−15, dy=15. A command valid during MOVE_X sees cmd_ready_out=0 and is accepted on return to WAIT. A command coincident with a trigger is used in that frame.
- Pause: pause_in=1 at trigger leaves outputs unchanged with no done_out. Trigger inputs held for several cycles produce exactly one update.
- Reset mid-operation: assert rst_n_in in T+2. Check that outputs immediately equal the reset values and that no done_out follows.
